// File: rtl/mem_access_unit.sv
// Load/store initiator for the big-endian, byte-addressed data memory port.
// Sub-word stores are done as read-modify-write; faults complete without touching memory.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES   = 128,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        RW,
    output logic [31:0] DAddr,
    output logic [31:0] DataIn,
    input  logic [31:0] mem_result
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StRmwRd,
        StRmwWr,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] datain_q, datain_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [32:0] last_byte;
    logic        range_fault;
    logic        fault;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_word;
    logic [31:0] merge_word;

    // Range is checked against the last byte of the enclosing word; 33 bits avoid wrap at the top.
    assign last_byte   = {1'b0, addr[31:2], 2'b00} + 33'd3;
    assign range_fault = CHECK_RANGE && (last_byte >= 33'(MEM_BYTES));
    assign fault       = (size == 2'b11)
                       || ((size == 2'b01) && addr[0])
                       || ((size == 2'b10) && (addr[1:0] != 2'b00))
                       || range_fault;

    // Lane extraction for loads (big-endian: lane 0 is the MSB byte).
    always_comb begin
        lane_byte = 8'h00;
        unique case (lane_q)
            2'd0: lane_byte = mem_result[31:24];
            2'd1: lane_byte = mem_result[23:16];
            2'd2: lane_byte = mem_result[15:8];
            2'd3: lane_byte = mem_result[7:0];
            default: lane_byte = 8'h00;
        endcase
        lane_half = lane_q[1] ? mem_result[15:0] : mem_result[31:16];
        case (size_q)
            2'b00:   load_word = {{24{sign_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_word = {{16{sign_q & lane_half[15]}}, lane_half};
            default: load_word = mem_result;
        endcase
    end

    // Read-modify-write merge: only the addressed lane takes store data.
    always_comb begin
        merge_word = mem_result;
        if (size_q == 2'b00) begin
            unique case (lane_q)
                2'd0: merge_word[31:24] = wdata_q[7:0];
                2'd1: merge_word[23:16] = wdata_q[7:0];
                2'd2: merge_word[15:8]  = wdata_q[7:0];
                2'd3: merge_word[7:0]   = wdata_q[7:0];
                default: merge_word = mem_result;
            endcase
        end else if (lane_q[1]) begin
            merge_word[15:0] = wdata_q[15:0];
        end else begin
            merge_word[31:16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        sign_d   = sign_q;
        lane_d   = lane_q;
        wdata_d  = wdata_q;
        rw_d     = 1'b0;
        daddr_d  = daddr_q;
        datain_d = datain_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    size_d  = size;
                    sign_d  = sign_ext;
                    lane_d  = addr[1:0];
                    wdata_d = wdata;
                    daddr_d = {addr[31:2], 2'b00};
                    if (fault) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d = 1'b0;
                        if (!we) begin
                            state_d = StRd;
                        end else if (size == 2'b10) begin
                            rw_d     = 1'b1;
                            datain_d = wdata;
                            state_d  = StWr;
                        end else begin
                            state_d = StRmwRd;
                        end
                    end
                end
            end
            StRd: begin
                rdata_d = load_word;
                state_d = StDone;
            end
            StWr: begin
                state_d = StDone;
            end
            StRmwRd: begin
                datain_d = merge_word;
                rw_d     = 1'b1;
                state_d  = StRmwWr;
            end
            StRmwWr: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
            lane_q   <= 2'b00;
            wdata_q  <= 32'h0;
            rw_q     <= 1'b0;
            daddr_q  <= 32'h0;
            datain_q <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            daddr_q  <= daddr_d;
            datain_q <= datain_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign rdata  = rdata_q;
    assign err    = err_q;
    assign RW     = rw_q;
    assign DAddr  = daddr_q;
    assign DataIn = datain_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a big-endian byte memory model.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, RW;
    logic [31:0] rdata, DAddr, DataIn, mem_result;

    mem_access_unit #(.MEM_BYTES(128), .CHECK_RANGE(1'b1)) dut (
        .CLK(CLK), .RST(RST), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
        .RW(RW), .DAddr(DAddr), .DataIn(DataIn), .mem_result(mem_result)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [0:127];
    int cyc = 0;
    int rw_cnt = 0;
    int last_rw_cyc = -1;
    int done_cnt = 0;
    int nchk = 0;
    int nfail = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
        string       name;
    } exp_t;
    exp_t sb[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RW) begin
            rw_cnt      = rw_cnt + 1;
            last_rw_cyc = cyc;
            if (DAddr <= 32'd124) begin
                mem[DAddr[6:0]]         = DataIn[31:24];
                mem[DAddr[6:0] + 7'd1]  = DataIn[23:16];
                mem[DAddr[6:0] + 7'd2]  = DataIn[15:8];
                mem[DAddr[6:0] + 7'd3]  = DataIn[7:0];
            end
        end
    end

    always_comb begin
        mem_result = 32'h0;
        if (DAddr <= 32'd124)
            mem_result = {mem[DAddr[6:0]], mem[DAddr[6:0] + 7'd1],
                          mem[DAddr[6:0] + 7'd2], mem[DAddr[6:0] + 7'd3]};
    end

    function automatic logic [31:0] mem_word(input logic [6:0] a);
        return {mem[a], mem[a + 7'd1], mem[a + 7'd2], mem[a + 7'd3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchk = nchk + 1;
        if (act !== expv) begin
            nfail = nfail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response.
    always @(negedge CLK) begin
        if (done) begin
            exp_t e;
            done_cnt = done_cnt + 1;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_done_cycle"}, cyc, e.cyc);
                chk({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
                if (e.chk_rd)
                    chk({e.name, "_rdata"}, rdata, e.rd);
            end
        end
    end

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk({name, "_timeout"}, 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_op(input string name, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input int lat,
                         input logic e_err, input logic chk_rd, input logic [31:0] e_rd,
                         input int e_rw);
        exp_t e;
        int   rw0;
        int   acc;
        @(negedge CLK);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        rw0 = rw_cnt;
        @(posedge CLK);
        #1;
        acc = cyc;
        req = 1'b0;
        e.cyc = acc + lat - 1; e.err = e_err; e.chk_rd = chk_rd; e.rd = e_rd; e.name = name;
        sb.push_back(e);
        wait_idle(name);
        chk({name, "_rw_cycles"}, rw_cnt - rw0, e_rw);
        if (e_rw > 0)
            chk({name, "_rw_when"}, last_rw_cyc, acc + lat - 2);
    endtask

    initial begin
        exp_t e;
        int a1;
        int d0;
        int rw0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;

        repeat (3) @(negedge CLK);
        chk("reset_RW", {31'd0, RW}, 32'd0);
        chk("reset_DAddr", DAddr, 32'd0);
        chk("reset_DataIn", DataIn, 32'd0);
        chk("reset_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        RST = 1'b1;

        // Word store, then loads of every lane shape
        do_op("st_w10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 0, 0, 32'h0, 1);
        chk("mem10_after_sw", mem_word(7'h10), 32'hDEADBEEF);
        do_op("lb11_s", 0, 2'b00, 1, 32'h11, 32'h0, 2, 0, 1, 32'hFFFFFFAD, 0);
        do_op("lb11_z", 0, 2'b00, 0, 32'h11, 32'h0, 2, 0, 1, 32'h000000AD, 0);
        do_op("lh12_s", 0, 2'b01, 1, 32'h12, 32'h0, 2, 0, 1, 32'hFFFFBEEF, 0);
        do_op("lb13_z", 0, 2'b00, 0, 32'h13, 32'h0, 2, 0, 1, 32'h000000EF, 0);
        do_op("lh10_z", 0, 2'b01, 0, 32'h10, 32'h0, 2, 0, 1, 32'h0000DEAD, 0);
        do_op("lw10", 0, 2'b10, 1, 32'h10, 32'h0, 2, 0, 1, 32'hDEADBEEF, 0);

        // Sub-word stores via read-modify-write
        do_op("sh12", 1, 2'b01, 0, 32'h12, 32'h00001234, 3, 0, 0, 32'h0, 1);
        chk("mem10_after_sh", mem_word(7'h10), 32'hDEAD1234);
        do_op("sb13", 1, 2'b00, 0, 32'h13, 32'hFFFFFF77, 3, 0, 0, 32'h0, 1);
        chk("mem10_after_sb13", mem_word(7'h10), 32'hDEAD1277);
        do_op("sb10", 1, 2'b00, 0, 32'h10, 32'h00000055, 3, 0, 0, 32'h0, 1);
        chk("mem10_after_sb10", mem_word(7'h10), 32'h55AD1277);

        // Faults complete in one cycle with err and no write
        do_op("f_lh13", 0, 2'b01, 0, 32'h13, 32'h0, 1, 1, 0, 32'h0, 0);
        do_op("f_sw12", 1, 2'b10, 0, 32'h12, 32'h11111111, 1, 1, 0, 32'h0, 0);
        do_op("f_sz11", 0, 2'b11, 0, 32'h20, 32'h0, 1, 1, 0, 32'h0, 0);
        do_op("f_sw7e", 1, 2'b10, 0, 32'h7E, 32'h22222222, 1, 1, 0, 32'h0, 0);
        do_op("f_sb80", 1, 2'b00, 0, 32'h80, 32'h33, 1, 1, 0, 32'h0, 0);
        chk("mem10_after_faults", mem_word(7'h10), 32'h55AD1277);
        chk("mem7c_after_faults", mem_word(7'h7C), 32'h0);
        do_op("lw7c", 0, 2'b10, 0, 32'h7C, 32'h0, 2, 0, 1, 32'h0, 0);

        // Reset during RMW_RD of a byte store
        @(negedge CLK);
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h10; wdata = 32'hAA;
        rw0 = rw_cnt;
        d0  = done_cnt;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        req = 1'b0;
        #1;
        chk("abort_RW", {31'd0, RW}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_write", rw_cnt - rw0, 0);
        chk("mem10_after_abort", mem_word(7'h10), 32'h55AD1277);
        do_op("lw10_post", 0, 2'b10, 0, 32'h10, 32'h0, 2, 0, 1, 32'h55AD1277, 0);

        // Back-to-back: req held high across a word store and a load
        d0 = done_cnt;
        @(negedge CLK);
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h40; wdata = 32'h12345678;
        @(posedge CLK);
        #1;
        a1 = cyc;
        e.cyc = a1 + 1; e.err = 1'b0; e.chk_rd = 1'b0; e.rd = 32'h0; e.name = "b2b_st";
        sb.push_back(e);
        @(negedge CLK);
        @(negedge CLK);
        we = 1'b0;
        @(posedge CLK);
        #1;
        chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
        e.cyc = a1 + 4; e.err = 1'b0; e.chk_rd = 1'b1; e.rd = 32'h12345678; e.name = "b2b_ld";
        sb.push_back(e);
        @(posedge CLK);
        #1;
        chk("b2b_second_busy", {31'd0, busy}, 32'd1);
        req = 1'b0;
        wait_idle("b2b");
        chk("b2b_done_pulses", done_cnt - d0, 2);

        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
